// File: rtl/water_level_sensor_filter.sv
// Synchronises, debounces and classifies the three tank float switches into level flags.
// Build option: define WATER_FAULT_LATCH_EN to make FAULT sticky after the first post-reset recovery.
module water_level_sensor_filter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FAULT_HOLD      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_low_sensor,
  input  logic       raw_mid_sensor,
  input  logic       raw_high_sensor,
  output logic       water_sensors_conflicting,
  output logic       high_water_level,
  output logic       low_water_level,
  output logic [1:0] water_level
);

  localparam int MAX_HOLD = (DEBOUNCE_CYCLES > FAULT_HOLD) ? DEBOUNCE_CYCLES : FAULT_HOLD;
  localparam int CW       = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FH_LAST  = CW'(FAULT_HOLD - 1);

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_LOW   = 3'd1,
    ST_MID   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c == CNT_MAX) sat_inc = c;
    else              sat_inc = c + CNT_ONE;
  endfunction

  function automatic logic is_consistent(input logic [2:0] p);
    case (p)
      3'b000, 3'b001, 3'b011, 3'b111: is_consistent = 1'b1;
      default:                        is_consistent = 1'b0;
    endcase
  endfunction

  function automatic state_t state_of(input logic [2:0] p);
    case (p)
      3'b001:  state_of = ST_LOW;
      3'b011:  state_of = ST_MID;
      3'b111:  state_of = ST_HIGH;
      default: state_of = ST_EMPTY;
    endcase
  endfunction

  function automatic logic [1:0] level_code(input state_t s);
    case (s)
      ST_LOW:  level_code = 2'd1;
      ST_MID:  level_code = 2'd2;
      ST_HIGH: level_code = 2'd3;
      default: level_code = 2'd0;
    endcase
  endfunction

  logic [2:0]         raw;
  logic [2:0]         sync_meta;
  logic [2:0]         sync;
  logic [2:0]         stable;
  logic [2:0]         stable_next;
  logic [2:0][CW-1:0] db_cnt;
  logic [2:0][CW-1:0] db_cnt_next;
  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      fault_cnt;
  logic [CW-1:0]      fault_cnt_next;
  logic               p_ok;
  logic               p_changed;
  logic               fault_locked;

  assign raw = {raw_high_sensor, raw_mid_sensor, raw_low_sensor};

  // Two-flop synchroniser for the asynchronous switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 3'b000;
      sync      <= 3'b000;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  // Per-switch debounce: flip the stable bit on the edge the disagreement count would hit the limit.
  always_comb begin
    stable_next = stable;
    db_cnt_next = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync[i] != stable[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          stable_next[i] = ~stable[i];
          db_cnt_next[i] = CNT_ZERO;
        end else begin
          db_cnt_next[i] = sat_inc(db_cnt[i]);
        end
      end else begin
        db_cnt_next[i] = CNT_ZERO;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 3'b000;
      db_cnt <= '0;
    end else begin
      stable <= stable_next;
      db_cnt <= db_cnt_next;
    end
  end

  // The FSM looks at the pattern the stable bits take on this edge, so a flip reaches the state with no extra cycle.
  assign p_ok      = is_consistent(stable_next);
  assign p_changed = (stable_next != stable);

`ifdef WATER_FAULT_LATCH_EN
  logic armed;

  // Arms on the first exit from FAULT; afterwards FAULT is left only through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
    end else if ((state == ST_FAULT) && (state_next != ST_FAULT)) begin
      armed <= 1'b1;
    end else begin
      armed <= armed;
    end
  end

  assign fault_locked = armed;
`else
  assign fault_locked = 1'b0;
`endif

  // Next-state logic: fault entry after FAULT_HOLD inconsistent cycles, recovery after FAULT_HOLD clean, unchanged cycles.
  always_comb begin
    state_next     = state;
    fault_cnt_next = CNT_ZERO;
    case (state)
      ST_EMPTY, ST_LOW, ST_MID, ST_HIGH: begin
        if (p_ok) begin
          state_next = state_of(stable_next);
        end else if (fault_cnt == FH_LAST) begin
          state_next = ST_FAULT;
        end else begin
          fault_cnt_next = sat_inc(fault_cnt);
        end
      end
      ST_FAULT: begin
        if (!p_ok || p_changed || fault_locked) begin
          fault_cnt_next = CNT_ZERO;
        end else if (fault_cnt == FH_LAST) begin
          state_next = state_of(stable_next);
        end else begin
          fault_cnt_next = sat_inc(fault_cnt);
        end
      end
      default: begin
        state_next = ST_FAULT;
      end
    endcase
  end

  // State register; reset lands in FAULT so the valve stays closed until the sensors agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FAULT;
      fault_cnt <= CNT_ZERO;
    end else begin
      state     <= state_next;
      fault_cnt <= fault_cnt_next;
    end
  end

  // Registered outputs decoded from the state being entered; the level is frozen while in FAULT.
  always_ff @(posedge clk) begin
    if (reset) begin
      water_sensors_conflicting <= 1'b1;
      high_water_level          <= 1'b0;
      low_water_level           <= 1'b0;
      water_level               <= 2'd0;
    end else begin
      water_sensors_conflicting <= (state_next == ST_FAULT);
      high_water_level          <= (state_next == ST_HIGH);
      low_water_level           <= (state_next == ST_EMPTY);
      if (state_next != ST_FAULT) begin
        water_level <= level_code(state_next);
      end else begin
        water_level <= water_level;
      end
    end
  end

endmodule

// File: tb/tb_water_level_sensor_filter.sv
// Directed bench for water_level_sensor_filter (DEBOUNCE_CYCLES=4, FAULT_HOLD=8).
module tb_water_level_sensor_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_low_sensor;
  logic       raw_mid_sensor;
  logic       raw_high_sensor;
  logic       water_sensors_conflicting;
  logic       high_water_level;
  logic       low_water_level;
  logic [1:0] water_level;

  int checks = 0;
  int errors = 0;

  water_level_sensor_filter #(
    .DEBOUNCE_CYCLES(4),
    .FAULT_HOLD     (8)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .raw_low_sensor           (raw_low_sensor),
    .raw_mid_sensor           (raw_mid_sensor),
    .raw_high_sensor          (raw_high_sensor),
    .water_sensors_conflicting(water_sensors_conflicting),
    .high_water_level         (high_water_level),
    .low_water_level          (low_water_level),
    .water_level              (water_level)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_raw(input logic [2:0] p);
    {raw_high_sensor, raw_mid_sensor, raw_low_sensor} = p;
  endtask

  // Compares {conflicting, high, low, level} against the hand-derived expectation.
  task automatic expect_outs(input string tag, input logic c, input logic h, input logic l,
                             input logic [1:0] lvl);
    logic [4:0] obs;
    logic [4:0] expd;
    obs  = {water_sensors_conflicting, high_water_level, low_water_level, water_level};
    expd = {c, h, l, lvl};
    checks++;
    assert (obs === expd)
    else begin
      errors++;
      $error("FAIL %s: observed conf/high/low/level=%b expected %b", tag, obs, expd);
    end
  endtask

  initial begin
    // 1: reset, then 8 clean cycles to EMPTY
    reset = 1'b1;
    set_raw(3'b000);
    tick(2);
    expect_outs("reset_state", 1'b1, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    tick(7);
    expect_outs("t1_still_fault", 1'b1, 1'b0, 1'b0, 2'd0);
    tick(1);
    expect_outs("t1_empty", 1'b0, 1'b0, 1'b1, 2'd0);

    // 2: staircase up, each level appears on the 6th edge after the drive (edge k+5)
    set_raw(3'b001);
    tick(5);
    expect_outs("t2_low_early", 1'b0, 1'b0, 1'b1, 2'd0);
    tick(1);
    expect_outs("t2_low", 1'b0, 1'b0, 1'b0, 2'd1);
    tick(4);
    set_raw(3'b011);
    tick(5);
    expect_outs("t2_mid_early", 1'b0, 1'b0, 1'b0, 2'd1);
    tick(1);
    expect_outs("t2_mid", 1'b0, 1'b0, 1'b0, 2'd2);
    tick(4);
    set_raw(3'b111);
    tick(5);
    expect_outs("t2_high_early", 1'b0, 1'b0, 1'b0, 2'd2);
    tick(1);
    expect_outs("t2_high", 1'b0, 1'b1, 1'b0, 2'd3);
    tick(4);

    // 3: drop straight to LOW, then mid-switch glitches of 3 and 4 samples
    set_raw(3'b001);
    tick(6);
    expect_outs("t3_low", 1'b0, 1'b0, 1'b0, 2'd1);
    tick(4);
    set_raw(3'b011);
    tick(3);
    set_raw(3'b001);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      expect_outs("t3_glitch3", 1'b0, 1'b0, 1'b0, 2'd1);
    end
    set_raw(3'b011);
    tick(4);
    set_raw(3'b001);
    tick(1);
    expect_outs("t3_glitch4_early", 1'b0, 1'b0, 1'b0, 2'd1);
    tick(1);
    expect_outs("t3_glitch4_mid", 1'b0, 1'b0, 1'b0, 2'd2);
    tick(3);
    expect_outs("t3_glitch4_hold", 1'b0, 1'b0, 1'b0, 2'd2);
    tick(1);
    expect_outs("t3_glitch4_back", 1'b0, 1'b0, 1'b0, 2'd1);

    // 4: MID, then inconsistent 101 until FAULT, then restore 011
    set_raw(3'b011);
    tick(6);
    expect_outs("t4_mid", 1'b0, 1'b0, 1'b0, 2'd2);
    tick(3);
    set_raw(3'b101);
    tick(12);
    expect_outs("t4_pre_fault", 1'b0, 1'b0, 1'b0, 2'd2);
    tick(1);
    expect_outs("t4_fault", 1'b1, 1'b0, 1'b0, 2'd2);
    tick(4);
    expect_outs("t4_fault_hold", 1'b1, 1'b0, 1'b0, 2'd2);
    set_raw(3'b011);
    tick(13);
    expect_outs("t4_recovering", 1'b1, 1'b0, 1'b0, 2'd2);
    tick(1);
`ifdef WATER_FAULT_LATCH_EN
    expect_outs("t4_latched", 1'b1, 1'b0, 1'b0, 2'd2);
    tick(10);
    expect_outs("t4_latched_long", 1'b1, 1'b0, 1'b0, 2'd2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(14);
    expect_outs("t4_after_reset_mid", 1'b0, 1'b0, 1'b0, 2'd2);
`else
    expect_outs("t4_recovered", 1'b0, 1'b0, 1'b0, 2'd2);
`endif

    // 5: HIGH, then short 110 excursion that must not reach FAULT
    set_raw(3'b111);
    tick(6);
    expect_outs("t5_high", 1'b0, 1'b1, 1'b0, 2'd3);
    tick(4);
    set_raw(3'b110);
    tick(5);
    set_raw(3'b111);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      expect_outs("t5_stay_high", 1'b0, 1'b1, 1'b0, 2'd3);
    end

    // 6: reset during a debounce count, then again during FAULT recovery
    set_raw(3'b110);
    tick(3);
    set_raw(3'b111);
    reset = 1'b1;
    tick(1);
    expect_outs("t6_reset_debounce", 1'b1, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    tick(10);
    expect_outs("t6_recovering", 1'b1, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    tick(1);
    expect_outs("t6_reset_recovery", 1'b1, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    tick(13);
    expect_outs("t6_restart_fault", 1'b1, 1'b0, 1'b0, 2'd0);
    tick(1);
    expect_outs("t6_restart_high", 1'b0, 1'b1, 1'b0, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
